gf2m_inverter: RTL

- Parametrised, handshaked GF(2^M) multiplicative inverter using the binary extended-Euclid algorithm, with one algorithm step per clock.
- Next-generation replacement for the fixed 7-bit load/poll inverter.
- Adds generic field width and reduction polynomial, valid/ready handshakes on both sides, asynchronous reset, zero-operand detection and flush.
- Feeds the point adder/doubler slope datapath.

---
 rtl/gf2m_pkg.sv | 20 ++
 rtl/gf2m_div_x.sv | 20 ++
 rtl/gf2m_inverter.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/gf2m_pkg.sv
// gf2m_pkg -- shared definitions for the GF(2^M) inverter.
//   GF_M_DEF / GF_POLY_DEF : default field degree and reduction polynomial
//   gf_state_e             : controller states
//   const_lat()            : accept-to-out_valid latency of the constant-time build
package gf2m_pkg;

  localparam int         GF_M_DEF    = 7;
  localparam logic [7:0] GF_POLY_DEF = 8'h83;  // x^7 + x + 1

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } gf_state_e;

  function automatic int const_lat(input int m);
    return 4 * m + 1;
  endfunction

endpackage

// File: rtl/gf2m_div_x.sv
// gf2m_div_x -- combinational divide-by-x modulo POLY.
//   g : M-bit field element (bit 0 = constant term)
//   q : g / x mod POLY
// An odd g is first made divisible by x by adding POLY (constant term 1).
module gf2m_div_x
  import gf2m_pkg::*;
#(
  parameter int         M    = GF_M_DEF,
  parameter logic [M:0] POLY = (M+1)'(GF_POLY_DEF)
) (
  input  logic [M-1:0] g,
  output logic [M-1:0] q
);

  // (g ^ POLY) >> 1 folded: POLY[0] cancels g[0], so only POLY[M:1] matters.
  always_comb begin
    q = {1'b0, g[M-1:1]} ^ ({M{g[0]}} & POLY[M:1]);
  end

endmodule

// File: rtl/gf2m_inverter.sv
// gf2m_inverter -- handshaked GF(2^M) inverter, binary extended Euclid,
// one algorithm step per clock.
//   clk, rst_n           : clock (rising edge), async active-low reset
//   flush                : synchronous abort back to IDLE (highest priority)
//   in_valid/in_ready    : operand handshake, in_ready high only in IDLE
//   in_a                 : operand, sampled only at accept
//   out_valid/out_ready  : result handshake, result held until taken
//   out_inv              : in_a^-1 mod POLY (0 for a zero operand)
//   out_zero_err         : operand was zero
//   busy                 : high while RUN
// Build option GF_INV_CONST_TIME_EN: every operand (zero included) takes
// exactly 4M+1 cycles from accept to out_valid; the datapath freezes once
// the result is found and a pad counter times the exit from RUN.
module gf2m_inverter
  import gf2m_pkg::*;
#(
  parameter int         M    = GF_M_DEF,
  parameter logic [M:0] POLY = (M+1)'(GF_POLY_DEF)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [M-1:0] in_a,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [M-1:0] out_inv,
  output logic         out_zero_err,
  output logic         busy
);

  localparam logic [M:0] ONE = (M+1)'(1);

  gf_state_e    state_q, state_d;
  logic [M:0]   u_q, u_d, v_q, v_d;
  logic [M-1:0] g1_q, g1_d, g2_q, g2_d;
  logic [M-1:0] inv_q, inv_d;
  logic         zero_q, zero_d;

  // one Euclid step, evaluated every cycle
  logic [M-1:0] g1_div, g2_div;
  logic [M:0]   su, sv;
  logic [M-1:0] sg1, sg2, hit_inv;
  logic         hit;

`ifdef GF_INV_CONST_TIME_EN
  localparam int            CW       = $clog2(4 * M + 2);
  // RUN is entered on the accept edge, so DONE must be entered on the
  // (4M)th edge after it; the counter reads 4M-1 at that edge.
  localparam logic [CW-1:0] PAD_LAST = CW'(const_lat(M) - 2);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          found_q, found_d;
`endif

  gf2m_div_x #(.M(M), .POLY(POLY)) u_div_g1 (.g(g1_q), .q(g1_div));
  gf2m_div_x #(.M(M), .POLY(POLY)) u_div_g2 (.g(g2_q), .q(g2_div));

  // invariants: g1*a == u, g2*a == v (mod POLY)
  always_comb begin
    hit     = 1'b0;
    hit_inv = g1_q;
    su      = u_q;
    sv      = v_q;
    sg1     = g1_q;
    sg2     = g2_q;
    if (u_q == ONE) begin
      hit     = 1'b1;
      hit_inv = g1_q;
    end else if (v_q == ONE) begin
      hit     = 1'b1;
      hit_inv = g2_q;
    end else if (!u_q[0]) begin
      su  = u_q >> 1;
      sg1 = g1_div;
    end else if (!v_q[0]) begin
      sv  = v_q >> 1;
      sg2 = g2_div;
    end else if (u_q >= v_q) begin
      su  = u_q ^ v_q;
      sg1 = g1_q ^ g2_q;
    end else begin
      sv  = v_q ^ u_q;
      sg2 = g2_q ^ g1_q;
    end
  end

  always_comb begin
    state_d = state_q;
    u_d     = u_q;
    v_d     = v_q;
    g1_d    = g1_q;
    g2_d    = g2_q;
    inv_d   = inv_q;
    zero_d  = zero_q;
`ifdef GF_INV_CONST_TIME_EN
    cnt_d   = cnt_q;
    found_d = found_q;
`endif
    if (flush) begin
      state_d = IDLE;
      inv_d   = '0;
      zero_d  = 1'b0;
`ifdef GF_INV_CONST_TIME_EN
      cnt_d   = '0;
      found_d = 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            u_d     = {1'b0, in_a};
            v_d     = POLY;
            g1_d    = '0;
            g1_d[0] = 1'b1;
            g2_d    = '0;
            zero_d  = 1'b0;
`ifdef GF_INV_CONST_TIME_EN
            cnt_d   = '0;
            found_d = 1'b0;
            state_d = RUN;
            if (in_a == '0) begin
              // result known up front; just pad out the latency
              inv_d   = '0;
              zero_d  = 1'b1;
              found_d = 1'b1;
            end
`else
            if (in_a == '0) begin
              inv_d   = '0;
              zero_d  = 1'b1;
              state_d = DONE;
            end else begin
              state_d = RUN;
            end
`endif
          end
        end
        RUN: begin
`ifdef GF_INV_CONST_TIME_EN
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == PAD_LAST) state_d = DONE;
          if (!found_q) begin
            u_d  = su;
            v_d  = sv;
            g1_d = sg1;
            g2_d = sg2;
            if (hit) begin
              inv_d   = hit_inv;
              found_d = 1'b1;
            end
          end
`else
          u_d  = su;
          v_d  = sv;
          g1_d = sg1;
          g2_d = sg2;
          if (hit) begin
            inv_d   = hit_inv;
            state_d = DONE;
          end
`endif
        end
        DONE: begin
          if (out_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      u_q     <= '0;
      v_q     <= '0;
      g1_q    <= '0;
      g2_q    <= '0;
      inv_q   <= '0;
      zero_q  <= 1'b0;
`ifdef GF_INV_CONST_TIME_EN
      cnt_q   <= '0;
      found_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      u_q     <= u_d;
      v_q     <= v_d;
      g1_q    <= g1_d;
      g2_q    <= g2_d;
      inv_q   <= inv_d;
      zero_q  <= zero_d;
`ifdef GF_INV_CONST_TIME_EN
      cnt_q   <= cnt_d;
      found_q <= found_d;
`endif
    end
  end

  assign in_ready     = (state_q == IDLE);
  assign out_valid    = (state_q == DONE);
  assign busy         = (state_q == RUN);
  assign out_inv      = inv_q;
  assign out_zero_err = zero_q;

endmodule
